// File: rtl/tx_frame_shift_reg_pkg.sv
// Shared UART definitions: frame sizing helper, parity selectors and line idle level.
package uart_pkg;

  localparam int   PARITY_EVEN = 0;
  localparam int   PARITY_ODD  = 1;
  localparam logic TXD_IDLE    = 1'b1;

  // Start bit + data + optional parity + stop bits.
  function automatic int frame_width(input int data_bits, input int parity_en,
                                     input int stop_bits);
    return 1 + data_bits + ((parity_en != 0) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/tx_frame_shift_reg_if.sv
// Load/tick/serial-line bundle between the UART transmit engine and the frame shifter.
interface tx_frame_shift_reg_if #(
  parameter int DATA_BITS = 8
);
  logic                 load;
  logic [DATA_BITS-1:0] d;
  logic                 shift;
  logic                 txd;
  logic                 busy;
  logic                 done;

  modport master (output load, d, shift, input  txd, busy, done);
  modport slave  (input  load, d, shift, output txd, busy, done);
endinterface

// File: rtl/tx_frame_shift_reg_bit_counter.sv
// Up-counter with synchronous clear and a terminal-count flag, used to track shifted frame bits.
module tx_bit_counter #(
  parameter int W  = 4,
  parameter int TC = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);
  localparam logic [W-1:0] TC_V = W'(TC);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TC_V);

endmodule

// File: rtl/tx_frame_shift_reg.sv
// UART transmit frame shifter: captures a word on load, builds start/data/parity/stop
// and shifts it out LSB-first one bit per baud tick, flagging busy and done.
module tx_frame_shift_reg #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  tx_frame_shift_reg_if.slave  bus
);
  import uart_pkg::frame_width;
  import uart_pkg::TXD_IDLE;

  localparam int FRAME_W = frame_width(DATA_BITS, PARITY_EN, STOP_BITS);
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam bit ODD_SEL = (PARITY_ODD == uart_pkg::PARITY_ODD);

  function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
    return ODD_SEL ? ~^w : ^w;
  endfunction

  logic [FRAME_W-1:0] sr_q, sr_d;
  logic               txd_q, txd_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [FRAME_W-1:0] frame_load;
  logic               load_acc;
  logic               tick;
  logic               cnt_tc;

  // Stop bits fill the top because frame_load starts as all ones.
  always_comb begin
    frame_load                = '1;
    frame_load[0]             = 1'b0;
    frame_load[DATA_BITS:1]   = bus.d;
    if (PARITY_EN != 0) begin
      frame_load[DATA_BITS+1] = parity_of(bus.d);
    end
  end

  assign load_acc = bus.load & ~busy_q;
  assign tick     = bus.shift & busy_q;

  tx_bit_counter #(
    .W  (CNT_W),
    .TC (FRAME_W - 1)
  ) u_cnt (
    .clk   (clk),
    .rst   (reset),
    .clr_i (load_acc | (tick & cnt_tc)),
    .inc_i (tick & ~cnt_tc),
    .tc_o  (cnt_tc)
  );

  // Load wins over shift while idle; while busy, load is ignored entirely.
  always_comb begin
    sr_d   = sr_q;
    txd_d  = txd_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (load_acc) begin
      sr_d   = frame_load;
      txd_d  = 1'b0;
      busy_d = 1'b1;
    end else if (tick) begin
      sr_d = {1'b1, sr_q[FRAME_W-1:1]};
      if (cnt_tc) begin
        txd_d  = TXD_IDLE;
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        txd_d  = sr_q[1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q   <= '1;
      txd_q  <= TXD_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      txd_q  <= txd_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign bus.txd  = txd_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_tx_frame_shift_reg.sv
// Bench for tx_frame_shift_reg: four configurations (8N1, 8E1, 8O1, 5N2) driven in lockstep,
// with frames predicted from the framing rules and compared when each DUT reports done.
module tb_tx_frame_shift_reg;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic       shift = 1'b0;
  logic [7:0] d = '0;

  always #5 clk = ~clk;

  tx_frame_shift_reg_if #(.DATA_BITS(8)) bus0 ();
  tx_frame_shift_reg_if #(.DATA_BITS(8)) bus1 ();
  tx_frame_shift_reg_if #(.DATA_BITS(8)) bus2 ();
  tx_frame_shift_reg_if #(.DATA_BITS(5)) bus3 ();

  assign bus0.load = load;  assign bus0.d = d;       assign bus0.shift = shift;
  assign bus1.load = load;  assign bus1.d = d;       assign bus1.shift = shift;
  assign bus2.load = load;  assign bus2.d = d;       assign bus2.shift = shift;
  assign bus3.load = load;  assign bus3.d = d[4:0];  assign bus3.shift = shift;

  tx_frame_shift_reg #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u0 (.clk(clk), .reset(reset), .bus(bus0));
  tx_frame_shift_reg #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    u1 (.clk(clk), .reset(reset), .bus(bus1));
  tx_frame_shift_reg #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
    u2 (.clk(clk), .reset(reset), .bus(bus2));
  tx_frame_shift_reg #(.DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
    u3 (.clk(clk), .reset(reset), .bus(bus3));

  logic txd_w [4];
  logic busy_w[4];
  logic done_w[4];
  assign txd_w[0] = bus0.txd;  assign busy_w[0] = bus0.busy;  assign done_w[0] = bus0.done;
  assign txd_w[1] = bus1.txd;  assign busy_w[1] = bus1.busy;  assign done_w[1] = bus1.done;
  assign txd_w[2] = bus2.txd;  assign busy_w[2] = bus2.busy;  assign done_w[2] = bus2.done;
  assign txd_w[3] = bus3.txd;  assign busy_w[3] = bus3.busy;  assign done_w[3] = bus3.done;

  localparam int DB[4] = '{8, 8, 8, 5};
  localparam int PE[4] = '{0, 1, 1, 0};
  localparam int PO[4] = '{0, 0, 1, 0};
  localparam int SB[4] = '{1, 1, 1, 2};

  int          errors = 0;
  int          checks = 0;
  bit          chk_en = 1'b0;
  bit          mbusy[4];
  bit          mdone[4];
  int          left[4];
  logic [11:0] q0[$], q1[$], q2[$], q3[$];
  logic [11:0] cap[4];
  int          ncap[4];

  function automatic int fw(int i);
    return 1 + DB[i] + PE[i] + SB[i];
  endfunction

  function automatic logic [11:0] fmask(int i);
    logic [11:0] m;
    m = '0;
    for (int b = 0; b < fw(i); b++) m[b] = 1'b1;
    return m;
  endfunction

  // Line order: start 0, data LSB first, parity making the total ones even (or odd), stop 1s.
  function automatic logic [11:0] build_frame(int i, logic [7:0] dv);
    logic [11:0] f;
    int          n;
    int          ones;
    f    = '1;
    f[0] = 1'b0;
    n    = 1;
    ones = 0;
    for (int b = 0; b < DB[i]; b++) begin
      f[n] = dv[b];
      ones += int'(dv[b]);
      n++;
    end
    if (PE[i] != 0) f[n] = ((ones % 2) == 1) ^ (PO[i] == 1);
    return f;
  endfunction

  function automatic void push_exp(int i, logic [11:0] f);
    case (i)
      0: q0.push_back(f);
      1: q1.push_back(f);
      2: q2.push_back(f);
      default: q3.push_back(f);
    endcase
  endfunction

  function automatic int qsize(int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic logic [11:0] pop_exp(int i);
    case (i)
      0: return q0.pop_front();
      1: return q1.pop_front();
      2: return q2.pop_front();
      default: return q3.pop_front();
    endcase
  endfunction

  function automatic void flush_exp(int i);
    case (i)
      0: q0.delete();
      1: q1.delete();
      2: q2.delete();
      default: q3.delete();
    endcase
  endfunction

  task automatic check(string name, int i, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d at %0t: got %0h expected %0h", name, i, $time, act, exp);
    end
  endtask

  // Reference: a load is taken only when idle; a frame ends after fw() ticks.
  task automatic model_update(logic l, logic [7:0] dv, logic s, logic r);
    for (int i = 0; i < 4; i++) begin
      mdone[i] = 1'b0;
      if (r) begin
        mbusy[i] = 1'b0;
        left[i]  = 0;
        flush_exp(i);
      end else if (!mbusy[i] && l) begin
        push_exp(i, build_frame(i, dv));
        mbusy[i] = 1'b1;
        left[i]  = fw(i);
      end else if (mbusy[i] && s) begin
        left[i]--;
        if (left[i] == 0) begin
          mbusy[i] = 1'b0;
          mdone[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic step(logic l, logic [7:0] dv, logic s, logic r);
    load  = l;
    d     = dv;
    shift = s;
    reset = r;
    @(posedge clk);
    model_update(l, dv, s, r);
    #1;
    load  = 1'b0;
    shift = 1'b0;
    reset = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic tick_gap(int gap);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    idle(gap - 1);
  endtask

  task automatic drain(int gap);
    int budget;
    budget = 40;
    while ((mbusy[0] || mbusy[1] || mbusy[2] || mbusy[3]) && budget > 0) begin
      tick_gap(gap);
      budget--;
    end
    if (budget == 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: frames still in flight after 40 ticks");
    end
    idle(3);
  endtask

  // Monitor: per-cycle status checks, bit capture on each tick, frame compare on done.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 4; i++) begin
        check("busy", i, 32'(busy_w[i]), 32'(mbusy[i]));
        check("done", i, 32'(done_w[i]), 32'(mdone[i]));
        if (!mbusy[i]) check("txd_idle", i, 32'(txd_w[i]), 32'd1);
        if (done_w[i] === 1'b1) begin
          if (qsize(i) == 0) begin
            check("done_without_frame", i, 32'(qsize(i)), 32'd1);
          end else begin
            logic [11:0] exp_f;
            exp_f = pop_exp(i);
            check("frame_len", i, 32'(ncap[i]), 32'(fw(i)));
            check("frame_bits", i, 32'(cap[i] & fmask(i)), 32'(exp_f & fmask(i)));
          end
          ncap[i] = 0;
        end
        if (reset) begin
          ncap[i] = 0;
        end else if (busy_w[i] === 1'b1 && shift) begin
          if (ncap[i] < 12) cap[i][ncap[i]] = txd_w[i];
          ncap[i]++;
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      mbusy[i] = 1'b0;
      mdone[i] = 1'b0;
      left[i]  = 0;
      cap[i]   = '1;
      ncap[i]  = 0;
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk_en = 1'b1;
    idle(3);

    // Plain frames, ticks 16 cycles apart.
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    idle(15);
    repeat (11) tick_gap(16);
    idle(4);
    step(1'b1, 8'h07, 1'b0, 1'b0);
    idle(15);
    repeat (11) tick_gap(16);
    idle(4);

    // Loads while busy are ignored, including on the final-shift edge; next cycle is taken.
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    idle(15);
    repeat (3) tick_gap(16);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    idle(14);
    repeat (6) tick_gap(16);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    idle(14);
    drain(16);

    // Reset mid-frame, then ticks with no load.
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    idle(15);
    repeat (4) tick_gap(16);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    repeat (3) tick_gap(16);
    idle(4);

    // Load and shift together while idle.
    step(1'b1, 8'hFF, 1'b1, 1'b0);
    idle(15);
    drain(16);

    // 5N2 pattern (also runs through the 8-bit configurations).
    step(1'b1, 8'h15, 1'b0, 1'b0);
    idle(15);
    drain(16);

    // Random traffic: loads at any time, ticks down to every cycle, rare resets.
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 9) == 0), 8'($urandom), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 499) == 0));
    end
    drain(2);

    for (int i = 0; i < 4; i++) check("queue_drained", i, 32'(qsize(i)), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tx_frame_shift_reg.md
Name: tx_frame_shift_reg

Overview:
Parametrised successor to the team's 8-bit load register, built for the UART transmit engine. It captures a parallel data word on load and builds the full serial frame: start bit, data LSB-first, optional parity, 1 or 2 stop bits. It then shifts the frame out one bit per bit-time tick from the baud generator. It reports busy while a frame is in flight and pulses done when the frame completes.

Parameters:
DATA_BITS, 8, data word width; legal range 5..9.
PARITY_EN, 0, 1 = append a parity bit after the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits; legal values 1..2.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
load  input  1  request to capture d and start a frame; honoured only when busy=0.
d  input  DATA_BITS  parallel data word.
shift  input  1  bit-time tick (1-cycle strobe from the baud generator).
txd  output  1  serial line, registered; idle level is 1.
busy  output  1  high from the cycle after an accepted load until the frame completes.
done  output  1  1-cycle pulse when the last stop bit has been shifted out.

Behaviour:
- Frame width FRAME_W = 1 + DATA_BITS + PARITY_EN + STOP_BITS.
- Internal FRAME_W-bit shift register sr; bit counter cnt, width $clog2(FRAME_W+1).
- Reset (synchronous, at a rising clk edge with reset=1): sr = all ones, txd=1, busy=0, done=0, cnt=0. Reset overrides load and shift in the same cycle, including mid-frame.
- IDLE (busy=0), load=1 at an edge:
  - sr <= {STOP_BITS ones, parity (if PARITY_EN), d, 1'b0}.
  - txd <= 0, which puts the start bit on the line in the following cycle.
  - busy <= 1, cnt <= 0.
- Parity value: ^d for even parity, ~^d for odd parity.
- IDLE, shift=1, load=0: no state change.
- IDLE, load=1 and shift=1 together: load is accepted; shift is ignored for that edge.
- BUSY, shift=1 at an edge:
  - sr <= {1'b1, sr[FRAME_W-1:1]}; txd <= sr[1]; cnt <= cnt+1.
  - Result: each frame bit stays on txd for exactly one shift interval.
- BUSY, shift=1 with cnt = FRAME_W-1 (the final shift):
  - txd <= 1, busy <= 0, done <= 1 for one cycle, cnt <= 0.
- BUSY, load=1: ignored, and d is not sampled. This includes the edge of the final shift, because busy is still 1 at that edge.
- A load in the cycle after done, when busy=0, is accepted. Back-to-back frames therefore need no gap beyond that one cycle.
- done is 0 on every cycle other than the completion cycle. done and busy are never high together.
- BUSY with shift=0: hold all state.
- Latency: load edge to start bit on txd = 1 cycle. Load to done = FRAME_W shift ticks.

Decomposition:
- Shared package uart_pkg:
  - function frame_width(data_bits, parity_en, stop_bits).
  - localparams PARITY_EVEN=0 and PARITY_ODD=1.
  - localparam TXD_IDLE=1'b1.
- One natural sub-module: tx_bit_counter. It is a parametrised up-counter with a sync clear and a terminal-count flag at FRAME_W-1, used for the cnt logic.
- The parity function stays inline in tx_frame_shift_reg.

Test Plan:
1. Defaults (8N1). Load 0xA5 while idle, then 10 shift ticks 16 cycles apart. Required txd sequence, one value per tick interval: 0,1,0,1,0,0,1,0,1,1. busy is high for exactly that span. done pulses once, at the 10th tick; txd=1 afterwards.
2. PARITY_EN=1, PARITY_ODD=0. Load 0x07 -> parity bit 1; frame is 0,1,1,1,0,0,0,0,0,1,1 (11 ticks). With PARITY_ODD=1 the same load gives parity bit 0.
3. Load 0x3C mid-frame of 0xA5. The 0xA5 frame must be unchanged and no second frame may start. A load of 0x3C the cycle after done must then produce 0,0,0,1,1,1,1,0,0,1.
4. Assert reset for one cycle after the 4th shift tick. On the next cycle txd=1, busy=0, done=0. Subsequent shifts produce no change until a new load.
5. While idle, assert load=1 and shift=1 in the same cycle with d=0xFF. The frame must start with start bit 0 held for a full tick interval, and then eight 1s.
6. STOP_BITS=2, DATA_BITS=5. Load 0x15 -> frame 0,1,0,1,0,1,1,1 (8 ticks). done pulses at the 8th tick.
